// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner: hold-FSM state encoding,
// counter-width helper and default timing constants.
// Optional feature macro used by this slice: BTN_AUTOREPEAT_EN.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } hold_state_t;

  // Defaults assume a 100 MHz system clock.
  localparam int DEF_N_BTN         = 5;
  localparam int DEF_DB_CYCLES     = 1000000;
  localparam int DEF_HOLD_CYCLES   = 100000000;
  localparam int DEF_REPEAT_CYCLES = 20000000;

  // Width of a counter that must be able to hold the value max_count.
  function automatic int cnt_width(input int unsigned max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: 2-flop synchroniser, counter debouncer, registered
// rise/fall pulses and the long-press (hold) FSM.
// With BTN_AUTOREPEAT_EN defined, the HELD state re-fires btn_hold every
// REPEAT_CYCLES cycles; otherwise HELD simply waits for release.
module btn_chan
  import btn_pkg::*;
#(
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic CLK,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic btn_hold
);

  localparam int DB_W     = cnt_width(DB_CYCLES);
  localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = cnt_width(HOLD_MAX);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYCLES - 1);
`endif

  logic              sync_meta;
  logic              sync_q;
  logic [DB_W-1:0]   db_cnt;
  logic              differs;
  logic              accept;
  logic              rise_evt;
  logic              fall_evt;
  hold_state_t       state;
  logic [HOLD_W-1:0] hold_cnt;

  // The accept cycle is when the synchronised input has disagreed with the
  // debounced level for DB_CYCLES consecutive cycles; the level flips then.
  assign differs  = (sync_q != btn_level);
  assign accept   = differs && (db_cnt == DB_LAST);
  assign rise_evt = accept && sync_q;
  assign fall_evt = accept && !sync_q;

  // Two-stage synchroniser for the asynchronous button input.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= btn_in;
      sync_q    <= sync_meta;
    end
  end

  // Debounce counter and level register; edge pulses share the flip cycle.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      db_cnt    <= '0;
      btn_level <= 1'b0;
      btn_rise  <= 1'b0;
      btn_fall  <= 1'b0;
    end else begin
      btn_rise <= rise_evt;
      btn_fall <= fall_evt;
      if (!differs) begin
        db_cnt <= '0;
      end else if (accept) begin
        btn_level <= sync_q;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + DB_ONE;
      end
    end
  end

  // Long-press FSM; it follows the level flip events so hold timing is
  // measured from the same cycle that btn_rise is shown.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      btn_hold <= 1'b0;
    end else begin
      btn_hold <= 1'b0;
      case (state)
        IDLE: begin
          if (rise_evt) begin
            state    <= PRESSED;
            hold_cnt <= '0;
          end
        end
        PRESSED: begin
          if (fall_evt) begin
            state    <= IDLE;
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            btn_hold <= 1'b1;
            hold_cnt <= '0;
            state    <= HELD;
          end else begin
            hold_cnt <= hold_cnt + HOLD_ONE;
          end
        end
        HELD: begin
          if (fall_evt) begin
            state    <= IDLE;
            hold_cnt <= '0;
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (hold_cnt == REPEAT_LAST) begin
            btn_hold <= 1'b1;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_ONE;
          end
`endif
        end
        default: begin
          state    <= IDLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel button conditioner: N_BTN independent btn_chan instances,
// each producing a debounced level, rise/fall pulses and a long-press pulse.
// Optional feature macro: BTN_AUTOREPEAT_EN (auto-repeat of btn_hold).
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN         = DEF_N_BTN,
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_rise,
  output logic [N_BTN-1:0] btn_fall,
  output logic [N_BTN-1:0] btn_hold
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_chan #(
      .DB_CYCLES     (DB_CYCLES),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_chan (
      .CLK       (CLK),
      .reset     (reset),
      .btn_in    (btn_in[i]),
      .btn_level (btn_level[i]),
      .btn_rise  (btn_rise[i]),
      .btn_fall  (btn_fall[i]),
      .btn_hold  (btn_hold[i])
    );
  end

endmodule
